instruction_prefetch_queue: RTL and testbench

INSTRUCTION_PREFETCH_QUEUE -- requirements
Module: instruction_prefetch_queue

---
 rtl/instruction_prefetch_queue.sv | 159 +++++++++++++++
 tb/tb_instruction_prefetch_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words over MMU port B into a
// DEPTH-entry FIFO and presents the head entry to decode on registered outputs.
// Build option: define PREFETCH_STATS_EN to add the 16-bit stallCount output.
module instruction_prefetch_queue #(
  parameter int unsigned          BUS_WIDTH = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [BUS_WIDTH-1:0] memAddr,
  output logic                 memRequest,
  input  logic [BUS_WIDTH-1:0] memData,
  input  logic                 memBusy,
  input  logic                 redirectValid,
  input  logic [BUS_WIDTH-1:0] redirectAddr,
  output logic [BUS_WIDTH-1:0] opcode,
  output logic [BUS_WIDTH-1:0] opcodePc,
  output logic                 opcodeValid,
  input  logic                 pop
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]          stallCount
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } stateT;

  stateT                state;
  stateT                nextState;
  logic [BUS_WIDTH-1:0] fetchPc;
  logic                 discard;

  logic [BUS_WIDTH-1:0] dataMem [DEPTH];
  logic [BUS_WIDTH-1:0] pcMem   [DEPTH];
  logic [PTR_W-1:0]     rdPtr;
  logic [PTR_W-1:0]     wrPtr;
  logic [CNT_W-1:0]     count;

  logic                 full;
  logic                 doPush;
  logic                 doPop;
  logic [BUS_WIDTH-1:0] redirectPc;
  logic [PTR_W-1:0]     nextRdPtr;
  logic [CNT_W-1:0]     keptCount;
  logic [CNT_W-1:0]     nextCount;

  // Queue bookkeeping: push/pop qualification and post-update pointer/occupancy.
  always_comb begin
    full       = (count == CNT_W'(DEPTH));
    doPush     = (state == WAIT) && !memBusy && !discard && !redirectValid;
    doPop      = pop && (count != '0);
    redirectPc = redirectAddr & ~BUS_WIDTH'(3);
    nextRdPtr  = rdPtr + PTR_W'(doPop);
    keptCount  = count - CNT_W'(doPop);
    nextCount  = keptCount + CNT_W'(doPush);
  end

  // Fetch FSM next-state logic.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (!full && !redirectValid) nextState = REQ;
      REQ:     nextState = WAIT;
      WAIT:    if (!memBusy) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // MMU request outputs; the address is captured on entry to REQ and held
  // for the whole access, so a redirect cannot disturb an outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      memRequest <= 1'b0;
      memAddr    <= '0;
    end else begin
      memRequest <= (nextState == REQ) || (nextState == WAIT);
      if ((state == IDLE) && (nextState == REQ)) memAddr <= fetchPc;
    end
  end

  // Discard flag marks an outstanding access whose response must be dropped.
  always_ff @(posedge clk) begin
    if (reset)                                              discard <= 1'b0;
    else if ((state == WAIT) && !memBusy)                   discard <= 1'b0;
    else if (redirectValid && ((state == REQ) || (state == WAIT))) discard <= 1'b1;
  end

  // Fetch address: redirect overrides the sequential +4 advance.
  always_ff @(posedge clk) begin
    if (reset)              fetchPc <= RESET_PC;
    else if (redirectValid) fetchPc <= redirectPc;
    else if (doPush)        fetchPc <= fetchPc + BUS_WIDTH'(4);
  end

  // Queue storage; written only when a response is accepted.
  always_ff @(posedge clk) begin
    if (!reset && doPush) begin
      dataMem[wrPtr] <= memData;
      pcMem[wrPtr]   <= fetchPc;
    end
  end

  // Pointers, occupancy and registered head outputs.
  // Head is loaded from the post-pop pointer, bypassing the incoming word
  // when it becomes the only entry, so no stale head survives a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      opcode      <= '0;
      opcodePc    <= '0;
      opcodeValid <= 1'b0;
    end else if (redirectValid) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      count       <= '0;
      opcodeValid <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      rdPtr       <= nextRdPtr;
      count       <= nextCount;
      opcodeValid <= (nextCount != '0);
      if (keptCount == '0) begin
        if (doPush) begin
          opcode   <= memData;
          opcodePc <= fetchPc;
        end
      end else begin
        opcode   <= dataMem[nextRdPtr];
        opcodePc <= pcMem[nextRdPtr];
      end
    end
  end

`ifdef PREFETCH_STATS_EN
  // Saturating count of cycles with no instruction available to decode.
  always_ff @(posedge clk) begin
    if (reset)                                     stallCount <= '0;
    else if (redirectValid)                        stallCount <= '0;
    else if (!opcodeValid && (stallCount != '1))   stallCount <= stallCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Self-checking bench for instruction_prefetch_queue: an MMU model answers
// requests, a scoreboard queue holds expected {pc, word} entries.
module tb_instruction_prefetch_queue;

  localparam int unsigned BW = 32;
  localparam int unsigned QD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] memAddr;
  logic          memRequest;
  logic [BW-1:0] memData;
  logic          memBusy;
  logic          redirectValid;
  logic [BW-1:0] redirectAddr;
  logic [BW-1:0] opcode;
  logic [BW-1:0] opcodePc;
  logic          opcodeValid;
  logic          pop;
`ifdef PREFETCH_STATS_EN
  logic [15:0]   stallCount;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [63:0]   sb[$];
  logic [BW-1:0] expPc;
  logic [BW-1:0] reqAddr;
  bit            inFlight, stale, prevReq, justDone, sawBad, badData, randBusy;
  int            reqAge, busyLen, reqCount;

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] dataOf(input logic [BW-1:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign memData = badData ? 32'hDEAD_BEEF : dataOf(memAddr);

  instruction_prefetch_queue #(
    .BUS_WIDTH(BW),
    .DEPTH(QD),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memAddr(memAddr),
    .memRequest(memRequest),
    .memData(memData),
    .memBusy(memBusy),
    .redirectValid(redirectValid),
    .redirectAddr(redirectAddr),
    .opcode(opcode),
    .opcodePc(opcodePc),
    .opcodeValid(opcodeValid),
    .pop(pop)
`ifdef PREFETCH_STATS_EN
    ,
    .stallCount(stallCount)
`endif
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle: compare outputs with the model, then apply the coming edge to the model.
  task automatic evaluate();
    logic [63:0] head;
    checkVal("valid", {31'd0, opcodeValid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      head = sb[0];
      checkVal("headPc", opcodePc, head[63:32]);
      checkVal("headOp", opcode, head[31:0]);
    end
    if (opcodeValid && (opcode == 32'hDEAD_BEEF)) sawBad = 1'b1;
    if (justDone) checkVal("reqDrop", {31'd0, memRequest}, 32'd0);
    if ((sb.size() == QD) && !inFlight) checkVal("fullIdle", {31'd0, memRequest}, 32'd0);
    if (memRequest && prevReq) checkVal("addrHold", memAddr, reqAddr);
    justDone = 1'b0;
    if (reset) begin
      sb.delete();
      expPc    = 32'h0;
      inFlight = 1'b0;
      stale    = 1'b0;
      prevReq  = 1'b0;
    end else begin
      if (memRequest && !prevReq) begin
        checkVal("reqAddr", memAddr, expPc);
        reqAddr  = expPc;
        inFlight = 1'b1;
        reqCount++;
      end
      if (pop && (sb.size() != 0)) void'(sb.pop_front());
      if (memRequest && prevReq && !memBusy) begin
        if (!stale && !redirectValid) begin
          sb.push_back({reqAddr, dataOf(reqAddr)});
          expPc = expPc + 32'd4;
        end
        inFlight = 1'b0;
        stale    = 1'b0;
        justDone = 1'b1;
      end else if (redirectValid && inFlight) begin
        stale = 1'b1;
      end
      if (redirectValid) begin
        sb.delete();
        expPc = redirectAddr & ~32'h3;
      end
      prevReq = memRequest;
    end
  endtask

  // One clock: check at negedge, then drive the MMU response shortly after posedge.
  task automatic step();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    if (memRequest) reqAge++;
    else begin
      reqAge  = 0;
      badData = 1'b0;
    end
    if ((reqAge == 1) && randBusy) busyLen = $urandom_range(0, 3);
    memBusy = (reqAge >= 2) && ((reqAge - 2) < busyLen);
  endtask

  task automatic waitInWait(input bit needValid);
    int n = 0;
    while (!((reqAge >= 2) && (!needValid || opcodeValid)) && (n < 60)) begin
      step();
      n++;
    end
    checkVal("reachWait", {31'd0, reqAge >= 2}, 32'd1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pop = 1'b0; redirectValid = 1'b0; redirectAddr = '0;
    memBusy = 1'b0; badData = 1'b0; randBusy = 1'b0; busyLen = 0; reqAge = 0;
    expPc = '0; reqAddr = '0; inFlight = 1'b0; stale = 1'b0; prevReq = 1'b0;
    justDone = 1'b0; sawBad = 1'b0; reqCount = 0;

    // Reset state
    doReset();
    checkVal("rstReq", {31'd0, memRequest}, 32'd0);
    checkVal("rstAddr", memAddr, 32'd0);
    checkVal("rstValid", {31'd0, opcodeValid}, 32'd0);
    checkVal("rstOp", opcode, 32'd0);
    checkVal("rstPc", opcodePc, 32'd0);
`ifdef PREFETCH_STATS_EN
    checkVal("rstStall", {16'd0, stallCount}, 32'd0);
`endif

    // Fill with no pops: requests 0,4,8,12 then idle while full
    reqCount = 0;
    for (int i = 0; i < 24; i++) step();
    checkVal("fillReqs", reqCount, 32'd4);
    checkVal("fillValid", {31'd0, opcodeValid}, 32'd1);
    checkVal("fillHeadPc", opcodePc, 32'd0);

    // Full queue, pop every cycle
    pop = 1'b1;
    for (int i = 0; i < 40; i++) step();
    pop = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Busy MMU for 5 WAIT cycles: request/address must hold
    pop = 1'b1;
    busyLen = 5;
    for (int i = 0; i < 40; i++) step();
    pop = 1'b0;

    // Redirect during WAIT with a poisoned response
    doReset();
    busyLen = 3;
    waitInWait(1'b0);
    badData = 1'b1;
    redirectValid = 1'b1;
    redirectAddr = 32'h100;
    step();
    redirectValid = 1'b0;
    for (int i = 0; i < 30 && !opcodeValid; i++) step();
    checkVal("redirHeadPc", opcodePc, 32'h100);
    checkVal("redirValid", {31'd0, opcodeValid}, 32'd1);
    checkVal("noDeadBeef", {31'd0, sawBad}, 32'd0);

    // Redirect, pop and push on the same edge; low address bits ignored
    busyLen = 0;
    waitInWait(1'b1);
    redirectValid = 1'b1;
    redirectAddr = 32'h203;
    pop = 1'b1;
    step();
    redirectValid = 1'b0;
    pop = 1'b0;
    checkVal("rppEmpty", {31'd0, opcodeValid}, 32'd0);
    for (int i = 0; i < 10 && !memRequest; i++) step();
    checkVal("rppAddr", memAddr, 32'h200);

    // Reset during WAIT abandons the access
    busyLen = 4;
    waitInWait(1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkVal("wrstReq", {31'd0, memRequest}, 32'd0);
    checkVal("wrstValid", {31'd0, opcodeValid}, 32'd0);
    busyLen = 0;
    for (int i = 0; i < 15; i++) step();

    // Random traffic: busy stretches, pops, redirects
    randBusy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pop = ($urandom_range(0, 1) == 1);
      redirectValid = ($urandom_range(0, 24) == 0);
      redirectAddr = $urandom;
      step();
    end
    redirectValid = 1'b0;
    pop = 1'b0;
    randBusy = 1'b0;
    checkVal("noDeadBeefEnd", {31'd0, sawBad}, 32'd0);

`ifdef PREFETCH_STATS_EN
    // Stall counter: count, clear on redirect, saturate
    busyLen = 100000;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checkVal("stall10", {16'd0, stallCount}, 32'd10);
    redirectValid = 1'b1;
    redirectAddr = 32'h40;
    step();
    redirectValid = 1'b0;
    checkVal("stallClr", {16'd0, stallCount}, 32'd0);
    for (int i = 0; i < 65540; i++) step();
    checkVal("stallSat", {16'd0, stallCount}, 32'h0000_FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
